// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter serialising four cores onto one single-port, synchronous-read RAM.
// Each access is IDLE -> ISSUE -> RESP, with a one-hot done pulse and broadcast read data.
module shared_ram_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  preset_n,
   input  logic [3:0]            req,
   input  logic [3:0]            we,
   input  logic [4*ADDR_W-1:0]   addr_in,
   input  logic [4*DATA_W-1:0]   wdata_in,
   output logic [3:0]            gnt,
   output logic [3:0]            done,
   output logic [DATA_W-1:0]     rdata,
   output logic                  busy,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_wdata,
   input  logic [DATA_W-1:0]     ram_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t              state, state_n;
   logic [1:0]          last, last_n;
   logic                hold_we, hold_we_n;
   logic [3:0]          gnt_n, done_n;
   logic [DATA_W-1:0]   rdata_n, ram_wdata_n;
   logic [ADDR_W-1:0]   ram_addr_n;
   logic                busy_n, ram_en_n, ram_we_n;

   logic [ADDR_W-1:0]   core_addr  [4];
   logic [DATA_W-1:0]   core_wdata [4];
   logic [3:0]          eligible;
   logic                win_found;
   logic [1:0]          win_idx, scan_idx;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         core_addr[i]  = addr_in[i*ADDR_W +: ADDR_W];
         core_wdata[i] = wdata_in[i*DATA_W +: DATA_W];
      end
   end

   // A core still seeing its done pulse is masked so a late req drop is not regranted.
   always_comb begin
      eligible  = req & ~done;
      win_found = 1'b0;
      win_idx   = last;
      scan_idx  = last;
      for (int k = 1; k <= 4; k++) begin
         scan_idx = last + 2'(k);
         if (!win_found && eligible[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_n     = state;
      last_n      = last;
      hold_we_n   = hold_we;
      gnt_n       = gnt;
      done_n      = 4'b0000;
      rdata_n     = rdata;
      ram_en_n    = 1'b0;
      ram_we_n    = 1'b0;
      ram_addr_n  = ram_addr;
      ram_wdata_n = ram_wdata;
      case (state)
         IDLE: begin
            if (win_found) begin
               last_n      = win_idx;
               hold_we_n   = we[win_idx];
               ram_addr_n  = core_addr[win_idx];
               ram_wdata_n = core_wdata[win_idx];
               gnt_n       = 4'b0001 << win_idx;
               ram_en_n    = 1'b1;
               ram_we_n    = we[win_idx];
               state_n     = ISSUE;
            end
         end
         ISSUE: begin
            state_n = RESP;
         end
         RESP: begin
            if (!hold_we) begin
               rdata_n = ram_rdata;
            end
            gnt_n   = 4'b0000;
            done_n  = 4'b0001 << last;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   // Reset starts with last = 3 so core 0 holds top priority.
   always_ff @(posedge clk or negedge preset_n) begin
      if (!preset_n) begin
         state     <= IDLE;
         last      <= 2'd3;
         hold_we   <= 1'b0;
         gnt       <= 4'b0000;
         done      <= 4'b0000;
         rdata     <= '0;
         busy      <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         state     <= state_n;
         last      <= last_n;
         hold_we   <= hold_we_n;
         gnt       <= gnt_n;
         done      <= done_n;
         rdata     <= rdata_n;
         busy      <= busy_n;
         ram_en    <= ram_en_n;
         ram_we    <= ram_we_n;
         ram_addr  <= ram_addr_n;
         ram_wdata <= ram_wdata_n;
      end
   end

endmodule
